uart_rx_oversample: RTL and testbench

UART receive front end that turns the asynchronous serial line into validated bytes for the downstream string-detect FSM (the "hello" checker). It samples 8N1 frames at 16x oversampling with a selectable baud rate and decides each bit by majority vote. Each good byte is presented with a one-cycle rx_done strobe. Frames with a bad stop bit are flagged and dropped, so the byte consumer never sees them.

---
 rtl/uart_rx_oversample.sv | 129 ++++++++++++
 tb/tb_uart_rx_oversample.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_rx_oversample.sv
// 8N1 UART receiver: 16x oversampling, 3-sample majority vote per bit, selectable baud.
// Good bytes strobe rx_done at mid stop bit; bad stop bits strobe frame_err and are dropped.
module uart_rx_oversample #(
  parameter int CLK_FREQ = 50_000_000
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [2:0] baud_set,
  input  logic       uart_rx,
  output logic [7:0] data_byte,
  output logic       rx_done,
  output logic       frame_err,
  output logic       busy
);

  localparam int DIV0 = CLK_FREQ / (9600 * 16);
  localparam int DIV1 = CLK_FREQ / (19200 * 16);
  localparam int DIV2 = CLK_FREQ / (38400 * 16);
  localparam int DIV3 = CLK_FREQ / (57600 * 16);
  localparam int DIV4 = CLK_FREQ / (115200 * 16);
  localparam int CW   = (DIV0 > 1) ? $clog2(DIV0) : 1;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t        state_q;
  logic          rx_meta_q, rx_s_q, rx_prev_q;
  logic [CW-1:0] div_m1_q, cnt_q, div_m1_sel;
  logic [3:0]    idx_q;
  logic [2:0]    bit_q;
  logic [1:0]    samp_q;
  logic [7:0]    shreg_q, data_byte_q;
  logic          rx_done_q, frame_err_q, busy_q;
  logic          tick, maj, start_det;

  always_comb begin
    case (baud_set)
      3'd1:    div_m1_sel = CW'(DIV1 - 1);
      3'd2:    div_m1_sel = CW'(DIV2 - 1);
      3'd3:    div_m1_sel = CW'(DIV3 - 1);
      3'd4:    div_m1_sel = CW'(DIV4 - 1);
      default: div_m1_sel = CW'(DIV0 - 1);
    endcase
  end

  assign tick      = (cnt_q == div_m1_q);
  // Samples from tick indices 7 and 8 are held; the index-9 sample is the live line.
  assign maj       = (samp_q[0] & samp_q[1]) | (samp_q[0] & rx_s_q) | (samp_q[1] & rx_s_q);
  assign start_det = rx_prev_q & ~rx_s_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rx_meta_q   <= 1'b1;
      rx_s_q      <= 1'b1;
      rx_prev_q   <= 1'b1;
      state_q     <= IDLE;
      div_m1_q    <= '0;
      cnt_q       <= '0;
      idx_q       <= '0;
      bit_q       <= '0;
      samp_q      <= '0;
      shreg_q     <= '0;
      data_byte_q <= '0;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      rx_meta_q   <= uart_rx;
      rx_s_q      <= rx_meta_q;
      rx_prev_q   <= rx_s_q;
      rx_done_q   <= 1'b0;
      frame_err_q <= 1'b0;

      if (state_q == IDLE) begin
        cnt_q <= '0;
        idx_q <= '0;
        bit_q <= '0;
        if (start_det) begin
          state_q  <= START;
          busy_q   <= 1'b1;
          div_m1_q <= div_m1_sel;
        end
      end else begin
        cnt_q <= tick ? '0 : cnt_q + CW'(1);
        if (tick) begin
          idx_q <= idx_q + 4'd1;
          if (idx_q == 4'd7) samp_q[0] <= rx_s_q;
          if (idx_q == 4'd8) samp_q[1] <= rx_s_q;
          case (state_q)
            START: begin
              if (idx_q == 4'd9 && maj) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
              end else if (idx_q == 4'd15) begin
                state_q <= DATA;
              end
            end
            DATA: begin
              if (idx_q == 4'd9) shreg_q <= {maj, shreg_q[7:1]};
              if (idx_q == 4'd15) begin
                if (bit_q == 3'd7) state_q <= STOP;
                else               bit_q   <= bit_q + 3'd1;
              end
            end
            STOP: begin
              // Leave at mid stop bit so a back-to-back start edge is not missed.
              if (idx_q == 4'd9) begin
                state_q <= IDLE;
                busy_q  <= 1'b0;
                if (maj) begin
                  data_byte_q <= shreg_q;
                  rx_done_q   <= 1'b1;
                end else begin
                  frame_err_q <= 1'b1;
                end
              end
            end
            default: state_q <= IDLE;
          endcase
        end
      end
    end
  end

  assign data_byte = data_byte_q;
  assign rx_done   = rx_done_q;
  assign frame_err = frame_err_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_uart_rx_oversample.sv
// Randomized and directed frame stimulus against a queue-based byte-level reference model.
module tb_uart_rx_oversample;

  localparam int CLK_FREQ = 6_000_000;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [2:0] baud_set = 3'd4;
  logic       uart_rx = 1'b1;
  logic [7:0] data_byte;
  logic       rx_done, frame_err, busy;

  uart_rx_oversample #(.CLK_FREQ(CLK_FREQ)) dut (
    .clk       (clk),
    .reset     (reset),
    .baud_set  (baud_set),
    .uart_rx   (uart_rx),
    .data_byte (data_byte),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy)
  );

  always #10 clk = ~clk;

  typedef struct {
    logic       err;
    logic [7:0] dat;
    int         start;
    int         d;
  } exp_t;

  exp_t       exp_q[$];
  exp_t       mon_e;
  int         n_vec = 0;
  int         n_err = 0;
  int         cyc = 0;
  int         lat;
  logic [7:0] last_good = 8'h00;
  logic       prev_strobe = 1'b0;
  logic [7:0] hello [5] = '{8'h68, 8'h65, 8'h6C, 8'h6C, 8'h6F};

  always @(posedge clk) cyc++;

  function automatic int d_of(input logic [2:0] bs);
    int baud;
    case (bs)
      3'd1:    baud = 19200;
      3'd2:    baud = 38400;
      3'd3:    baud = 57600;
      3'd4:    baud = 115200;
      default: baud = 9600;
    endcase
    return CLK_FREQ / (baud * 16);
  endfunction

  task automatic chk(input string name, input int act, input int exp_v);
    n_vec++;
    if (act != exp_v) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp_v);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic idle(input int bits, input int d);
    uart_rx = 1'b1;
    step(bits * 16 * d);
  endtask

  task automatic check_reset_outputs();
    chk("reset_data_byte", int'(data_byte), 0);
    chk("reset_rx_done", int'(rx_done), 0);
    chk("reset_frame_err", int'(frame_err), 0);
    chk("reset_busy", int'(busy), 0);
  endtask

  // Frame index 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
  task automatic send_frame(input logic [7:0] b, input int d, input logic stop_v,
                            input int glitch_idx, input int abort_idx, input logic track);
    exp_t e;
    logic v;
    if (track) begin
      e.err   = !stop_v;
      e.dat   = stop_v ? b : last_good;
      e.start = cyc;
      e.d     = d;
      exp_q.push_back(e);
      if (stop_v) last_good = b;
    end
    for (int fi = 0; fi < 10; fi++) begin
      if (fi == 0)      v = 1'b0;
      else if (fi == 9) v = stop_v;
      else              v = b[fi-1];
      for (int c = 0; c < 16 * d; c++) begin
        if (fi == abort_idx && c == 8 * d) begin
          uart_rx = 1'b1;
          return;
        end
        uart_rx = (fi == glitch_idx && c >= 9*d - d/2 && c < 9*d - d/2 + d) ? ~v : v;
        step(1);
      end
    end
  endtask

  always @(negedge clk) begin
    if (!reset && (rx_done || frame_err)) begin
      chk("strobe_exclusive", int'(rx_done & frame_err), 0);
      chk("strobe_width", int'(prev_strobe), 0);
      if (exp_q.size() == 0) begin
        n_vec++;
        n_err++;
        $display("FAIL unexpected_strobe: got rx_done=%0b frame_err=%0b, expected none",
                 rx_done, frame_err);
      end else begin
        mon_e = exp_q.pop_front();
        chk("strobe_kind_frame_err", int'(frame_err), int'(mon_e.err));
        chk("data_byte", int'(data_byte), int'(mon_e.dat));
        lat = cyc - mon_e.start;
        n_vec++;
        if (lat < 154 * mon_e.d + 1 || lat > 154 * mon_e.d + 5) begin
          n_err++;
          $display("FAIL latency: got %0d clocks, expected %0d +/- 2", lat, 154 * mon_e.d + 3);
        end
      end
    end
    prev_strobe = !reset && (rx_done || frame_err);
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog: simulation exceeded its cycle budget");
    $fatal(1, "watchdog");
  end

  initial begin
    int         d, gap;
    logic [7:0] rb;
    logic       sv;

    step(3);
    check_reset_outputs();
    reset = 1'b0;
    step(2);

    // Single byte at the fastest rate.
    baud_set = 3'd4;
    d = d_of(3'd4);
    send_frame(8'h68, d, 1'b1, -1, -1, 1'b1);
    idle(2, d);
    chk("busy_after_single", int'(busy), 0);

    // "hello" back-to-back at the slowest rate.
    baud_set = 3'd0;
    d = d_of(3'd0);
    for (int i = 0; i < 5; i++) send_frame(hello[i], d, 1'b1, -1, -1, 1'b1);
    idle(1, d);
    chk("busy_after_hello", int'(busy), 0);

    // False start: short low pulse.
    baud_set = 3'd4;
    d = d_of(3'd4);
    uart_rx = 1'b0;
    step(3 * d);
    chk("busy_false_start_high", int'(busy), 1);
    uart_rx = 1'b1;
    step(16 * d);
    chk("busy_false_start_low", int'(busy), 0);

    // Glitch on the middle sample of data bit 2.
    send_frame(8'h55, d, 1'b1, 3, -1, 1'b1);
    idle(2, d);

    // Framing error between two good bytes.
    send_frame(8'h3C, d, 1'b1, -1, -1, 1'b1);
    send_frame(8'hA5, d, 1'b0, -1, -1, 1'b1);
    idle(2, d);
    send_frame(8'h42, d, 1'b1, -1, -1, 1'b1);
    idle(2, d);

    // Reset during data bit 4, then a fresh frame.
    send_frame(8'hF0, d, 1'b1, -1, 5, 1'b0);
    step(2);
    reset = 1'b1;
    step(1);
    reset = 1'b0;
    check_reset_outputs();
    last_good = 8'h00;
    idle(12, d);
    send_frame(8'h81, d, 1'b1, -1, -1, 1'b1);
    idle(2, d);

    // baud_set change mid-frame must not disturb the latched rate.
    fork
      send_frame(8'h5A, d, 1'b1, -1, -1, 1'b1);
      begin
        step(5 * 16 * d);
        baud_set = 3'd3;
      end
    join
    idle(2, d);
    d = d_of(3'd3);
    send_frame(8'hC3, d, 1'b1, -1, -1, 1'b1);
    idle(2, d);

    // Random bytes, rates, stop bits and gaps.
    for (int i = 0; i < 10; i++) begin
      baud_set = 3'($urandom_range(3, 4));
      d   = d_of(baud_set);
      rb  = 8'($urandom);
      sv  = ($urandom_range(0, 4) != 0);
      gap = $urandom_range(0, 2);
      if (!sv && gap == 0) gap = 1;
      send_frame(rb, d, sv, -1, -1, 1'b1);
      idle(gap, d);
    end
    idle(2, d);

    for (int i = 0; i < 1000 && exp_q.size() != 0; i++) step(1);
    chk("pending_expected_strobes", exp_q.size(), 0);
    chk("busy_final", int'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
